// File: rtl/pipelined_chunk_adder.sv
// Pipelined ripple-chunk adder/subtractor with valid/ready flow control.
// Each stage resolves one CHUNK-bit slice and registers the carry onward.
module pipelined_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  s_q   [STAGES];
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] sub_q;
    logic [STAGES-1:0] sat_q;

    logic [WIDTH-1:0]  a_src [STAGES];
    logic [WIDTH-1:0]  b_src [STAGES];
    logic [WIDTH-1:0]  s_src [STAGES];
    logic [WIDTH-1:0]  s_nxt [STAGES];
    logic [CHUNK:0]    part  [STAGES];
    logic [STAGES-1:0] v_src;
    logic [STAGES-1:0] c_src;
    logic [STAGES-1:0] c_nxt;
    logic [STAGES-1:0] sub_src;
    logic [STAGES-1:0] sat_src;
    logic [STAGES-1:0] adv;

    always_comb begin
        a_src[0]   = in_a;
        b_src[0]   = in_sub ? ~in_b : in_b;
        s_src[0]   = '0;
        c_src[0]   = in_cin ^ in_sub;
        v_src[0]   = in_valid;
        sub_src[0] = in_sub;
        sat_src[0] = in_sat;
        for (int k = 1; k < STAGES; k++) begin
            a_src[k]   = a_q[k-1];
            b_src[k]   = b_q[k-1];
            s_src[k]   = s_q[k-1];
            c_src[k]   = c_q[k-1];
            v_src[k]   = v_q[k-1];
            sub_src[k] = sub_q[k-1];
            sat_src[k] = sat_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            part[k] = {1'b0, a_src[k][k*CHUNK +: CHUNK]}
                    + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, c_src[k]};
            s_nxt[k] = s_src[k];
            s_nxt[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
            c_nxt[k] = part[k][CHUNK];
        end
        // A stage moves when any stage at or after it has a hole, or the sink drains.
        for (int k = 0; k < STAGES; k++) begin
            adv[k] = out_ready
                   | ((v_q | STAGES'((1 << k) - 1)) != {STAGES{1'b1}});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            c_q   <= '0;
            sub_q <= '0;
            sat_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    v_q[k] <= v_src[k];
                    if (v_src[k]) begin
                        a_q[k]   <= a_src[k];
                        b_q[k]   <= b_src[k];
                        s_q[k]   <= s_nxt[k];
                        c_q[k]   <= c_nxt[k];
                        sub_q[k] <= sub_src[k];
                        sat_q[k] <= sat_src[k];
                    end
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v_q[LAST];
    assign out_cout  = c_q[LAST];
    assign out_ovf   = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1])
                     & (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

    // Saturation only reshapes the sum; flags always report the raw result.
    always_comb begin
        out_sum = s_q[LAST];
        if (sat_q[LAST]) begin
            if (sub_q[LAST] && !c_q[LAST]) begin
                out_sum = '0;
            end else if (!sub_q[LAST] && c_q[LAST]) begin
                out_sum = '1;
            end
        end
    end

endmodule
